// File: rtl/irq_save_restore_ctrl.sv
// -----------------------------------------------------------------------------
// irq_save_restore_ctrl
//
// Sequential interrupt entry/exit controller for the register file's r12/r13
// save/restore path. External requests are edge-detected into a pending set,
// masked and prioritised (lowest index wins). Entry from IDLE drains the
// pipeline, writes the captured EX-stage PC to r12 and the flags to r13 through
// the normal write port, then redirects fetch to the selected vector. IRET
// inside the handler restores flags from r13 and returns to the PC held in r12.
//
// Ports:
//   clk                    system clock
//   rst_n                  asynchronous active-low reset
//   i_irq_req[N_IRQ]       level request lines (rising edge = new request)
//   i_irq_mask[N_IRQ]      1 = line enabled
//   i_pc_ex[32]            PC of the instruction in EX
//   i_flags_ex[2]          current flags
//   i_is_iret              IRET in EX this cycle
//   i_saved_pc[32]         register file r12 read data
//   i_saved_flags[32]      register file r13 read data
//   o_stall                freeze fetch/decode
//   o_flush                squash IF/ID/EX
//   o_wb_en                register file write enable
//   o_wb_addr[4]           write register index
//   o_wb_data[32]          write data
//   o_pc_redirect          load o_pc_target into PC
//   o_pc_target[32]        redirect address
//   o_flags_restore_valid  load o_flags_restore into flag register
//   o_flags_restore[2]     restored flags
//   o_irq_ack[N_IRQ]       one-hot acknowledge pulse
//   o_in_isr               handler executing
//   o_iret_err             IRET seen outside a handler
// -----------------------------------------------------------------------------
module irq_save_restore_ctrl #(
  parameter int          N_IRQ        = 4,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] VEC_BASE     = 32'd64,
  parameter logic [31:0] VEC_STRIDE   = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] i_irq_req,
  input  logic [N_IRQ-1:0] i_irq_mask,
  input  logic [31:0]      i_pc_ex,
  input  logic [1:0]       i_flags_ex,
  input  logic             i_is_iret,
  input  logic [31:0]      i_saved_pc,
  input  logic [31:0]      i_saved_flags,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_wb_en,
  output logic [3:0]       o_wb_addr,
  output logic [31:0]      o_wb_data,
  output logic             o_pc_redirect,
  output logic [31:0]      o_pc_target,
  output logic             o_flags_restore_valid,
  output logic [1:0]       o_flags_restore,
  output logic [N_IRQ-1:0] o_irq_ack,
  output logic             o_in_isr,
  output logic             o_iret_err
);

  // Index width stays at least 1 so a single-line build still elaborates.
  localparam int          IDX_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FLUSH      = 3'd1,
    S_SAVE_PC    = 3'd2,
    S_SAVE_FLAGS = 3'd3,
    S_VECTOR     = 3'd4,
    S_IN_ISR     = 3'd5,
    S_RESTORE    = 3'd6,
    S_RETURN     = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [N_IRQ-1:0]   r_prev_req;
  logic [N_IRQ-1:0]   r_pending;
  logic [31:0]        r_cap_pc;
  logic [1:0]         r_cap_flags;
  logic [IDX_W-1:0]   r_idx;
  logic [3:0]         r_drain_cnt;
  logic               r_iret_err;

  logic [N_IRQ-1:0]   w_rise;
  logic [N_IRQ-1:0]   w_eligible;
  logic [N_IRQ-1:0]   w_ack;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_take;
  logic               w_unused_flags;

  // Only the low two bits of r13 carry flags.
  assign w_unused_flags = ^i_saved_flags[31:2];

  assign w_rise     = i_irq_req & ~r_prev_req;
  assign w_eligible = r_pending & i_irq_mask;

  // Entry is refused in a cycle where IRET is also present in EX.
  assign w_take = (r_state == S_IDLE) && (w_eligible != '0) && !i_is_iret;

  // Priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    w_win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win_idx = IDX_W'(i);
      end
    end
  end

  // One-hot acknowledge; the same pulse clears the serviced pending bit.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_ack
      assign w_ack[gi] = (r_state == S_VECTOR) && (r_idx == IDX_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: edge detect, pending set, capture, drain counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_req  <= '0;
      r_pending   <= '0;
      r_cap_pc    <= '0;
      r_cap_flags <= '0;
      r_idx       <= '0;
      r_drain_cnt <= '0;
      r_iret_err  <= 1'b0;
    end else begin
      r_prev_req <= i_irq_req;
      // Set is applied after clear so a fresh edge coinciding with the
      // acknowledge keeps the bit pending.
      r_pending  <= (r_pending & ~w_ack) | w_rise;
      r_iret_err <= (r_state == S_IDLE) && i_is_iret;

      if (w_take) begin
        r_cap_pc    <= i_pc_ex;
        r_cap_flags <= i_flags_ex;
        r_idx       <= w_win_idx;
        r_drain_cnt <= DRAIN_LOAD;
      end else if ((r_state == S_FLUSH) && (r_drain_cnt != 4'd0)) begin
        r_drain_cnt <= r_drain_cnt - 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Moore output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next          = r_state;
    o_stall               = 1'b0;
    o_flush               = 1'b0;
    o_wb_en               = 1'b0;
    o_wb_addr             = 4'd0;
    o_wb_data             = 32'd0;
    o_pc_redirect         = 1'b0;
    o_pc_target           = 32'd0;
    o_flags_restore_valid = 1'b0;
    o_flags_restore       = 2'b00;
    o_in_isr              = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        o_stall = 1'b1;
        o_flush = 1'b1;
        // Counter was loaded with DRAIN_CYCLES-1, so exit on zero gives
        // exactly DRAIN_CYCLES flush cycles.
        if (r_drain_cnt == 4'd0) begin
          w_state_next = S_SAVE_PC;
        end
      end
      S_SAVE_PC: begin
        o_stall      = 1'b1;
        o_wb_en      = 1'b1;
        o_wb_addr    = 4'd12;
        o_wb_data    = r_cap_pc;
        w_state_next = S_SAVE_FLAGS;
      end
      S_SAVE_FLAGS: begin
        o_stall      = 1'b1;
        o_wb_en      = 1'b1;
        o_wb_addr    = 4'd13;
        o_wb_data    = {30'd0, r_cap_flags};
        w_state_next = S_VECTOR;
      end
      S_VECTOR: begin
        o_stall       = 1'b1;
        o_pc_redirect = 1'b1;
        o_pc_target   = VEC_BASE + (32'(r_idx) * VEC_STRIDE);
        w_state_next  = S_IN_ISR;
      end
      S_IN_ISR: begin
        // No nesting: new edges only accumulate in the pending set.
        o_in_isr = 1'b1;
        if (i_is_iret) begin
          w_state_next = S_RESTORE;
        end
      end
      S_RESTORE: begin
        o_stall               = 1'b1;
        o_flush               = 1'b1;
        o_flags_restore_valid = 1'b1;
        o_flags_restore       = i_saved_flags[1:0];
        w_state_next          = S_RETURN;
      end
      S_RETURN: begin
        // Always passes through IDLE; no tail-chaining into FLUSH.
        o_stall       = 1'b1;
        o_pc_redirect = 1'b1;
        o_pc_target   = i_saved_pc;
        w_state_next  = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_irq_ack  = w_ack;
  assign o_iret_err = r_iret_err;

endmodule

// File: doc/irq_save_restore_ctrl.md
Name: irq_save_restore_ctrl

Overview:
- Sequential writer for the register file's interrupt save/restore path.
- Replaces edge-triggered r12/r13 capture with a clocked FSM:
  - latches and prioritises external interrupt requests;
  - drains the pipeline;
  - writes EX-stage PC to r12 and flags to r13 through the normal write port;
  - redirects fetch to a vector.
- On IRET it restores flags from r13 and returns to the PC held in r12.
- Sits between the EX stage, the register file write port and the fetch PC mux.

Parameters:
- N_IRQ, 4, number of interrupt request lines (1..8)
- DRAIN_CYCLES, 2, flush cycles before saving (1..15)
- VEC_BASE, 32'd64, address of vector 0
- VEC_STRIDE, 32'd4, spacing between vectors

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_req  in  N_IRQ  level request lines, rising edge = new request
- irq_mask  in  N_IRQ  1 = line enabled
- pc_ex  in  32  PC of instruction in EX
- flags_ex  in  2  current flags
- is_iret  in  1  IRET in EX this cycle
- saved_pc  in  32  register file r12 read data
- saved_flags  in  32  register file r13 read data
- stall  out  1  freeze fetch/decode
- flush  out  1  squash IF/ID/EX
- wb_en  out  1  register file write enable
- wb_addr  out  4  write register index
- wb_data  out  32  write data
- pc_redirect  out  1  load pc_target into PC
- pc_target  out  32  redirect address
- flags_restore_valid  out  1  load flags_restore into flag register
- flags_restore  out  2  restored flags
- irq_ack  out  N_IRQ  one-hot acknowledge pulse
- in_isr  out  1  handler executing
- iret_err  out  1  IRET outside handler

Behaviour:
Reset:
- Clock and reset are one clock, clk; reset rst_n is asynchronous, active-low.
- Reset forces state IDLE and clears pending, prev_req, cap_pc, cap_flags, idx and drain counter.
- All outputs are 0 on reset; wb_addr = 0 and pc_target = 0.
- Reset mid-sequence aborts with no further writes or redirects.

Pending and priority:
- prev_req registers irq_req each cycle.
- pending[i] is set at the clock edge where irq_req[i]=1 and prev_req[i]=0.
- pending[i] is cleared in the VECTOR cycle when i is the serviced index.
- A new rising edge in the same cycle as the clear wins: the bit stays set.
- A line held high through reset release registers one request.
- Eligible = pending & irq_mask. Lowest index has highest priority.
- Masked pending bits are retained.

States (outputs are Moore, decoded from registered state):
- IDLE:
  - Eligible != 0 and is_iret=0 -> FLUSH.
  - On that edge capture cap_pc=pc_ex, cap_flags=flags_ex, idx = winning index; load drain counter = DRAIN_CYCLES-1.
  - is_iret=1 in IDLE: iret_err=1 for 1 cycle, no other effect, and an interrupt is not taken that cycle.
- FLUSH: stall=1, flush=1. Counter decrements; exits to SAVE_PC when it reaches 0, so the state lasts exactly DRAIN_CYCLES cycles.
- SAVE_PC: stall=1, wb_en=1, wb_addr=12, wb_data=cap_pc.
- SAVE_FLAGS: stall=1, wb_en=1, wb_addr=13, wb_data={30'b0,cap_flags}.
- VECTOR:
  - stall=1, pc_redirect=1, pc_target=VEC_BASE+idx*VEC_STRIDE (32-bit, wrap ignored).
  - irq_ack[idx]=1; clear pending[idx].
  - Next state IN_ISR.
- IN_ISR:
  - in_isr=1. No nesting: new edges only set pending.
  - is_iret=1 -> RESTORE.
- RESTORE: stall=1, flush=1, flags_restore_valid=1, flags_restore=saved_flags[1:0].
- RETURN:
  - stall=1, pc_redirect=1, pc_target=saved_pc. Next state IDLE.
  - Any eligible pending request is taken from IDLE one cycle later (tail-chaining is not supported).

Latency:
- Request edge sampled at edge E0.
- FLUSH entered at E1.
- With defaults, irq_ack/pc_redirect is high in the cycle after E5.
- Total interrupt entry = DRAIN_CYCLES+3 cycles after FLUSH entry.

Test Plan:
- irq_req[2] rises, mask=4'hF, pc_ex=0x100, flags_ex=2'b10 -> 2 flush cycles.
  - Next cycle: wb 12<=0x100.
  - Next cycle: wb 13<=0x2.
  - Next cycle: pc_target=0x48, irq_ack=4'b0100, then in_isr=1.
- irq_req[1] and [3] rise same cycle -> line 1 serviced, target 0x44. After IRET, line 3 is taken from IDLE with target 0x4C.
- In IN_ISR, is_iret=1 with saved_pc=0x104, saved_flags=0x1:
  - cycle 1: flags_restore_valid=1, flags_restore=2'b01;
  - cycle 2: pc_redirect=1, pc_target=0x104, then IDLE.
- irq_req[0] rises with mask[0]=0 -> no entry. Mask set 10 cycles later -> entry begins next cycle; line held high produces no second request.
- rst_n low during SAVE_PC -> outputs 0 immediately. After release: IDLE, pending=0, no wb to r13.
- is_iret=1 in IDLE -> iret_err pulses 1 cycle, no redirect or flag restore.
